des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; the DES widths (64-bit key, 48-bit subkey, 16 rounds) SHALL be fixed.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 start  input  1  Request a new schedule; sampled only in IDLE.
REQ-005 key  input  64  DES key; key[63] = FIPS bit 1; parity bits ignored.
REQ-006 decrypt  input  1  Direction select, sampled with start: 0 = K1..K16 order, 1 = K16..K1 order.
REQ-007 subkey  output  48  Current round subkey; subkey[47] = PC-2 output bit 1.
REQ-008 subkey_round  output  4  DES index of the presented subkey minus 1 (K1 -> 0, K16 -> 15).
REQ-009 subkey_valid  output  1  Subkey and subkey_round are valid.
REQ-010 subkey_ready  input  1  Consumer accepts the subkey; a transfer occurs when valid and ready are both 1.
REQ-011 busy  output  1  High from the cycle after start is accepted until the cycle after done.
REQ-012 done  output  1  Single-cycle pulse after the 16th transfer.

Function
REQ-013 FSM states SHALL be IDLE, GEN and DONE.
REQ-014 IDLE -> GEN: on start=1, the block SHALL load C,D = PC-1(key) (28+28 bits) and latch decrypt.
REQ-015 GEN -> DONE: on the 16th transfer.
REQ-016 DONE -> IDLE: unconditionally after one cycle, with done=1 during that cycle.
REQ-017 Shift schedule: s(i) = 1 for rounds i = 1, 2, 9, 16; s(i) = 2 otherwise.
REQ-018 Encrypt, round i: C,D SHALL be rotated left by s(i), then Ki = PC-2(C,D).
REQ-019 Decrypt, first output: K16 = PC-2(C0,D0), with no rotation, because C16,D16 = C0,D0.
REQ-020 Decrypt, each later output K(17-j) for j = 2..16: C,D SHALL first be rotated right by s(18-j).
REQ-021 Subkeys SHALL be held in registers (PC-2 output registered); subkey_valid SHALL rise in the cycle after start is accepted (latency 1).
REQ-022 After each transfer, the next subkey SHALL be valid in the following cycle; back-to-back transfers with ready held high SHALL give 16 subkeys in 16 consecutive cycles.
REQ-023 While subkey_valid=1 and subkey_ready=0, subkey and subkey_round SHALL hold stable.
REQ-024 subkey_valid SHALL NOT be withdrawn before its transfer.
REQ-025 start SHALL be ignored while in GEN or DONE.
REQ-026 key and decrypt changes after acceptance SHALL NOT affect the schedule in progress.
REQ-027 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-028 subkey_valid SHALL be 0 in IDLE and DONE.
REQ-029 subkey_round SHALL increment 0..15 in encrypt and decrement 15..0 in decrypt.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and clear C, D, subkey, subkey_round, subkey_valid, busy and done to 0.
REQ-031 Reset asserted mid-schedule SHALL abort the schedule with no done pulse; the first start after rst_n rises SHALL begin a fresh schedule.
REQ-032 Outputs SHALL stay at reset values until the first accepted start after rst_n deasserts.

Verification
REQ-033 key=0x133457799BBCDFF1, decrypt=0, ready=1 -> first subkey 0x1B02EFFC7072 with subkey_round=0 at start+1; subkey 0xCB3D8B0E17F5 with subkey_round=15 at start+16; done at start+17.
REQ-034 Same key, decrypt=1 -> first subkey 0xCB3D8B0E17F5 with subkey_round=15; last subkey 0x1B02EFFC7072 with subkey_round=0; the full sequence SHALL equal the reverse of REQ-033.
REQ-035 Random ready stalls over REQ-033 -> subkey and subkey_round stable during every stall; exactly 16 transfers; done one cycle after the last transfer.
REQ-036 start pulsed with a different key during GEN -> no effect; the sequence matches the originally latched key.
REQ-037 rst_n pulsed low at round 7 -> all outputs 0 immediately with no done pulse; the next start yields the correct full sequence.
REQ-038 Reference-model sweep of 1000 random keys in both directions -> every subkey matches the model; encrypt and decrypt sequences are mutual reverses.

Source files
------------

// File: rtl/des_key_sched_if.sv
// Handshake bundle for the DES key scheduler: a request side (start/key/decrypt)
// and a subkey stream with valid/ready flow control.
interface des_key_sched_if;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, key, decrypt, subkey_ready,
        input  subkey, subkey_round, subkey_valid, busy, done
    );

    modport slave (
        input  start, key, decrypt, subkey_ready,
        output subkey, subkey_round, subkey_valid, busy, done
    );
endinterface

// File: rtl/des_key_sched.sv
// DES key schedule generator: streams the 16 round subkeys in encrypt (K1..K16)
// or decrypt (K16..K1) order, one per accepted valid/ready transfer.
module des_key_sched (
    input  logic            clk,
    input  logic            rst_n,
    des_key_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    // Tables hold FIPS bit numbers, 1 = most significant bit of the source.
    localparam logic [5:0] PC1_TAB [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - int'(PC1_TAB[6'(i)]))];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - int'(PC2_TAB[6'(i)]))];
        return r;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic single);
        return single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic single);
        return single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Zero-based round index r is DES round r+1; rounds 1, 2, 9 and 16 shift by one.
    function automatic logic one_shift(input logic [3:0] r);
        return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
    endfunction

    state_t      state;
    state_t      state_next;
    logic [27:0] c;
    logic [27:0] d;
    logic [27:0] c_nxt;
    logic [27:0] d_nxt;
    logic [55:0] cd_pc1;
    logic        dec_mode;
    logic [47:0] subkey_q;
    logic [3:0]  round_q;
    logic        valid;
    logic        xfer;
    logic        last;

    assign valid = (state == GEN);
    assign xfer  = valid && bus.subkey_ready;
    assign last  = dec_mode ? (round_q == 4'd0) : (round_q == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = GEN;
            GEN:     if (xfer && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decrypt walks the rotations backwards: K16 uses C0,D0 directly because the
    // sixteen left shifts sum to a full 28-bit revolution.
    always_comb begin
        cd_pc1 = pc1(bus.key);
        c_nxt  = c;
        d_nxt  = d;
        if (state == IDLE) begin
            if (bus.decrypt) begin
                c_nxt = cd_pc1[55:28];
                d_nxt = cd_pc1[27:0];
            end else begin
                c_nxt = rol28(cd_pc1[55:28], 1'b1);
                d_nxt = rol28(cd_pc1[27:0], 1'b1);
            end
        end else if (dec_mode) begin
            c_nxt = ror28(c, one_shift(round_q));
            d_nxt = ror28(d, one_shift(round_q));
        end else begin
            c_nxt = rol28(c, one_shift(round_q + 4'd1));
            d_nxt = rol28(d, one_shift(round_q + 4'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c        <= '0;
            d        <= '0;
            dec_mode <= 1'b0;
            subkey_q <= '0;
            round_q  <= '0;
        end else if (state == IDLE && bus.start) begin
            c        <= c_nxt;
            d        <= d_nxt;
            dec_mode <= bus.decrypt;
            subkey_q <= pc2({c_nxt, d_nxt});
            round_q  <= bus.decrypt ? 4'd15 : 4'd0;
        end else if (xfer && !last) begin
            c        <= c_nxt;
            d        <= d_nxt;
            subkey_q <= pc2({c_nxt, d_nxt});
            round_q  <= dec_mode ? (round_q - 4'd1) : (round_q + 4'd1);
        end
    end

    assign bus.subkey       = subkey_q;
    assign bus.subkey_round = round_q;
    assign bus.subkey_valid = valid;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: a table-driven DES key-schedule model fills
// an expectation queue at each request, and a negedge monitor checks every transfer.
module tb_des_key_sched;

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;

    int pc1_tab [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    int pc2_tab [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int shift_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk;
    logic rst_n;
    des_key_sched_if bus ();

    des_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    exp_t        exp_q [$];
    logic [47:0] ref_keys [16];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ki is C0,D0 rotated left by the running total of shifts, then PC-2.
    function automatic void compute_ref(input logic [63:0] k);
        bit cd0 [56];
        int total;
        int p;
        for (int n = 0; n < 56; n++)
            cd0[n] = k[6'(64 - pc1_tab[n])];
        total = 0;
        for (int i = 0; i < 16; i++) begin
            total += shift_tab[i];
            for (int m = 0; m < 48; m++) begin
                p = pc2_tab[m];
                if (p <= 28)
                    ref_keys[i][6'(47 - m)] = cd0[(p - 1 + total) % 28];
                else
                    ref_keys[i][6'(47 - m)] = cd0[28 + (p - 29 + total) % 28];
            end
        end
    endfunction

    function automatic void push_expected(input logic [63:0] k, input logic dec);
        exp_t e;
        int   r;
        compute_ref(k);
        for (int j = 0; j < 16; j++) begin
            r       = dec ? 15 - j : j;
            e.key   = ref_keys[r];
            e.round = 4'(r);
            e.last  = (j == 15);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: pops on each valid&&ready, checks stall stability and done timing.
    bit          expect_done;
    bit          prev_stall;
    logic [47:0] prev_key;
    logic [3:0]  prev_round;
    int          xfer_count;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            expect_done = 0;
            prev_stall  = 0;
            xfer_count  = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", 64'(bus.subkey_valid), 64'd1);
                checkOutput("hold_subkey", 64'(bus.subkey), 64'(prev_key));
                checkOutput("hold_round", 64'(bus.subkey_round), 64'(prev_round));
            end
            checkOutput("done_timing", 64'(bus.done), 64'(expect_done));
            if (bus.done) begin
                checkOutput("xfer_count", 64'(xfer_count), 64'd16);
                xfer_count = 0;
            end
            expect_done = 0;
            if (bus.subkey_valid && bus.subkey_ready) begin
                checkOutput("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("subkey", 64'(bus.subkey), 64'(e.key));
                    checkOutput("subkey_round", 64'(bus.subkey_round), 64'(e.round));
                    xfer_count++;
                    if (e.last) expect_done = 1;
                end
            end
            prev_stall = bus.subkey_valid && !bus.subkey_ready;
            prev_key   = bus.subkey;
            prev_round = bus.subkey_round;
        end
    end

    task automatic applyStimulus(input logic [63:0] k, input logic dec, input bit stall);
        @(posedge clk);
        #1;
        bus.key          = k;
        bus.decrypt      = dec;
        bus.start        = 1'b1;
        bus.subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        push_expected(k, dec);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.key     = {$urandom, $urandom};
        bus.decrypt = ~dec;
        bus.subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic wait_done(input bit stall, input bit interfere, output int cycles);
        bit fin;
        fin    = 0;
        cycles = 0;
        while (!fin) begin
            @(negedge clk);
            if (cycles == 0) begin
                checkOutput("valid_latency", 64'(bus.subkey_valid), 64'd1);
                checkOutput("busy_gen", 64'(bus.busy), 64'd1);
            end
            if (bus.done) begin
                fin = 1;
            end else if (cycles > 400) begin
                checkOutput("done_timeout", 64'(bus.done), 64'd1);
                fin = 1;
            end else begin
                @(posedge clk);
                #1;
                cycles++;
                bus.subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (interfere && cycles == 5) begin
                    bus.start   = 1'b1;
                    bus.key     = {$urandom, $urandom};
                    bus.decrypt = 1'($urandom_range(0, 1));
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_subkey"}, 64'(bus.subkey), 64'd0);
        checkOutput({tag, "_round"}, 64'(bus.subkey_round), 64'd0);
        checkOutput({tag, "_valid"}, 64'(bus.subkey_valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          cyc;
        bit          hit;
        logic [63:0] k;
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.key          = '0;
        bus.decrypt      = 1'b0;
        bus.subkey_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("post_reset_idle");

        compute_ref(KNOWN_KEY);
        checkOutput("ref_k1", 64'(ref_keys[0]), 64'h1B02EFFC7072);
        checkOutput("ref_k16", 64'(ref_keys[15]), 64'hCB3D8B0E17F5);

        $display("[TB] known vector, encrypt and decrypt");
        applyStimulus(KNOWN_KEY, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, cyc);
        checkOutput("enc_done_latency", 64'(cyc), 64'd16);
        applyStimulus(KNOWN_KEY, 1'b1, 1'b0);
        wait_done(1'b0, 1'b0, cyc);
        checkOutput("dec_done_latency", 64'(cyc), 64'd16);

        $display("[TB] random ready stalls");
        for (int n = 0; n < 6; n++) begin
            k = (n == 0) ? KNOWN_KEY : {$urandom, $urandom};
            applyStimulus(k, 1'(n % 2), 1'b1);
            wait_done(1'b1, 1'b0, cyc);
        end

        $display("[TB] start pulsed during generation");
        applyStimulus({$urandom, $urandom}, 1'b0, 1'b0);
        wait_done(1'b0, 1'b1, cyc);
        applyStimulus({$urandom, $urandom}, 1'b1, 1'b1);
        wait_done(1'b1, 1'b1, cyc);

        $display("[TB] start held across the done cycle");
        k = {$urandom, $urandom};
        bus.key     = k;
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        push_expected(k, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("start_in_done_ignored", 64'(bus.subkey_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(1'b0, 1'b0, cyc);
        checkOutput("restart_done_latency", 64'(cyc), 64'd16);

        $display("[TB] reset at round 7");
        applyStimulus({$urandom, $urandom}, 1'b0, 1'b0);
        hit = 0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            if (bus.subkey_valid && bus.subkey_round == 4'd7) hit = 1;
        end
        checkOutput("reached_round7", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("after_abort");
        applyStimulus(KNOWN_KEY, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, cyc);

        $display("[TB] random key sweep");
        for (int n = 0; n < 1000; n++) begin
            k = {$urandom, $urandom};
            applyStimulus(k, 1'b0, n % 97 == 0);
            wait_done(n % 97 == 0, 1'b0, cyc);
            applyStimulus(k, 1'b1, 1'b0);
            wait_done(1'b0, 1'b0, cyc);
        end

        @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
